// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Constants and types used by the Y86-64 pipeline control logic.
//   icode_e      : instruction codes as they appear in the pipeline registers
//   stat_e       : status codes carried through the M and W stages
//   REG_NONE     : register id meaning "no register"
//   ctrl_state_e : control state machine states (RUN / DRAIN / HALTED)
// ----------------------------------------------------------------------------
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    // Instructions whose result only becomes available after the memory stage.
    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, counts on rising edge
//   rst   : asynchronous active-high clear
//   inc   : count enable for this cycle
//   count : current value (W bits)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment when enabled unless already at the maximum value, so a long
    // run reports "at least this many" rather than a misleading small number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the 5-stage Y86-64 pipeline, placed beside E.
// Detects load/use, ret and mispredict hazards, owns the condition codes,
// sequences RUN -> DRAIN -> HALTED on exceptional status and keeps counters.
//   Inputs : D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, alu_zf/sf/of,
//            M_icode, m_stat, W_icode, W_stat, clk, rst (async, active high)
//   Outputs: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall (pipeline
//            register control), set_cc, ZF/SF/OF (registered CC), halted,
//            cycle_cnt, instr_cnt (saturating, CNT_W bits)
// ----------------------------------------------------------------------------
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    ctrl_state_e state;
    ctrl_state_e state_next;

    logic loaduse;
    logic ret_haz;
    logic mispred;
    logic stat_bad;
    logic cycle_inc;
    logic instr_inc;

    // Hazard detection. A load in E whose destination feeds D must hold D one
    // cycle; a ret anywhere in D/E/M blocks fetch until its target is known;
    // a not-taken jump in E means the two younger instructions are wrong-path.
    always_comb begin
        loaduse = is_mem_load(E_icode) && (E_dstM != REG_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_haz = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred = (E_icode == I_JXX) && !e_Cnd;
        stat_bad = (m_stat != S_AOK) || (W_stat != S_AOK);
    end

    // State register. Reset always returns to RUN, even mid-drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state. An exception reaching W halts at once; one seen in M first
    // drains so the faulting instruction can reach W. HALTED waits for reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (W_stat != S_AOK) begin
                    state_next = HALTED;
                end else if (m_stat != S_AOK) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (W_stat != S_AOK) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output decode. A load/use stall wins over the ret bubble in D so the
    // D register is never told to both hold and clear. During DRAIN younger
    // instructions keep flowing but are bubbled out before memory and never
    // touch the condition codes. HALTED freezes the whole pipe.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (state)
            RUN, DRAIN: begin
                F_stall  = loaduse | ret_haz;
                D_stall  = loaduse;
                D_bubble = mispred | (ret_haz & ~loaduse);
                E_bubble = mispred | loaduse;
                M_bubble = (state == DRAIN);
                set_cc   = (state == RUN) && (E_icode == I_OPQ) && !stat_bad;
            end
            HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: begin
                F_stall  = 1'b0;
            end
        endcase
    end

    assign halted = (state == HALTED);

    // Condition-code register; reset value reflects a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ZF <= 1'b1;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if (set_cc) begin
            ZF <= alu_zf;
            SF <= alu_sf;
            OF <= alu_of;
        end
    end

    // Counter enables. A HALT retiring carries HLT status, so it is excluded
    // by the AOK test; bubbles are excluded by the NOP test.
    always_comb begin
        cycle_inc = (state != HALTED);
        instr_inc = (state != HALTED) && (W_stat == S_AOK) && (W_icode != I_NOP);
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cycle_inc),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_inc),
        .count (instr_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl with a narrow counter width so saturation is
// reachable. Stimulus pushes expected responses into a queue; a monitor pops
// and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int CW = 4;
    localparam int MAXCNT = (1 << CW) - 1;

    // Flag vector layout: F_stall D_stall D_bubble E_bubble M_bubble W_stall
    // set_cc | ZF SF OF | halted
    localparam logic [10:0] M_HAZ = 11'b1111111_000_1;
    localparam logic [10:0] M_ALL = 11'b1111111_111_1;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic e_Cnd, alu_zf, alu_sf, alu_of;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic ZF, SF, OF, halted;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    typedef struct {
        logic       rst;
        logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
        logic       e_Cnd, alu_zf, alu_sf, alu_of;
        logic [2:0] m_stat, W_stat;
    } stim_t;

    typedef struct {
        string         name;
        logic [10:0]   flags;
        logic [10:0]   mask;
        logic [CW-1:0] cyc;
        logic          cycCare;
        logic [CW-1:0] ins;
        logic          insCare;
    } exp_t;

    exp_t expQ[$];
    int checkCount = 0;
    int passCount = 0;
    int modelCycles = 0;
    int modelInstr = 0;
    bit benchHalted = 1'b0;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .ZF(ZF), .SF(SF), .OF(OF), .halted(halted),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 1'b0;
        s.D_icode = 4'h1; s.d_srcA = 4'hF; s.d_srcB = 4'hF;
        s.E_icode = 4'h1; s.E_dstM = 4'hF; s.M_icode = 4'h1; s.W_icode = 4'h1;
        s.e_Cnd = 1'b1; s.alu_zf = 1'b0; s.alu_sf = 1'b0; s.alu_of = 1'b0;
        s.m_stat = 3'd1; s.W_stat = 3'd1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst;
        D_icode = s.D_icode; d_srcA = s.d_srcA; d_srcB = s.d_srcB;
        E_icode = s.E_icode; E_dstM = s.E_dstM; M_icode = s.M_icode;
        W_icode = s.W_icode; e_Cnd = s.e_Cnd;
        alu_zf = s.alu_zf; alu_sf = s.alu_sf; alu_of = s.alu_of;
        m_stat = s.m_stat; W_stat = s.W_stat;
    endtask

    // Advance one clock, update the counter expectations for the edge just
    // taken (using the inputs that were held across it), then drive new inputs.
    task automatic applyStimulus(input stim_t s, input bit haltsAtEdge);
        @(posedge clk);
        if (!rst && !benchHalted) begin
            if (modelCycles < MAXCNT) modelCycles++;
            if (W_stat == 3'd1 && W_icode != 4'h1 && modelInstr < MAXCNT) modelInstr++;
        end
        if (haltsAtEdge) benchHalted = 1'b1;
        #1;
        drive(s);
        if (s.rst) begin
            modelCycles = 0;
            modelInstr = 0;
            benchHalted = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [10:0] flags,
                               input logic [10:0] mask, input bit cycCare,
                               input bit insCare);
        exp_t e;
        e.name = name; e.flags = flags; e.mask = mask;
        e.cyc = CW'(modelCycles); e.cycCare = cycCare;
        e.ins = CW'(modelInstr); e.insCare = insCare;
        expQ.push_back(e);
    endtask

    // Monitor: compare every pending expectation on the falling edge.
    initial begin
        exp_t e;
        logic [10:0] obs;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                obs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
                       set_cc, ZF, SF, OF, halted};
                checkCount++;
                if (((obs & e.mask) !== (e.flags & e.mask)) ||
                    (e.cycCare && (cycle_cnt !== e.cyc)) ||
                    (e.insCare && (instr_cnt !== e.ins))) begin
                    $display("[TB] FAIL %s: flags got %b want %b (mask %b), cycle_cnt got %0d want %0d, instr_cnt got %0d want %0d",
                             e.name, obs, e.flags, e.mask, cycle_cnt, e.cyc,
                             instr_cnt, e.ins);
                end else begin
                    passCount++;
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = idleStim();
        s.rst = 1'b1;
        drive(s);

        // Reset and hazard decode
        applyStimulus(s, 1'b0);
        checkOutput("reset", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);
        s = idleStim();
        applyStimulus(s, 1'b0);
        checkOutput("idle_run", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);

        s = idleStim(); s.E_icode = 4'h5; s.E_dstM = 4'h3; s.d_srcA = 4'h3;
        applyStimulus(s, 1'b0);
        checkOutput("loaduse_srcA", 11'b1101000_000_0, M_HAZ, 1'b1, 1'b0);

        s.d_srcA = 4'hF; s.d_srcB = 4'hF;
        applyStimulus(s, 1'b0);
        checkOutput("loaduse_clear", 11'b0000000_000_0, M_HAZ, 1'b0, 1'b0);

        s = idleStim(); s.E_icode = 4'hB; s.E_dstM = 4'h4; s.d_srcB = 4'h4;
        applyStimulus(s, 1'b0);
        checkOutput("loaduse_popq_srcB", 11'b1101000_000_0, M_HAZ, 1'b0, 1'b0);

        s = idleStim(); s.E_icode = 4'h5; s.E_dstM = 4'hF; s.d_srcA = 4'h2;
        applyStimulus(s, 1'b0);
        checkOutput("load_no_dst", 11'b0000000_000_0, M_HAZ, 1'b0, 1'b0);

        s = idleStim(); s.E_icode = 4'h7; s.e_Cnd = 1'b0; s.D_icode = 4'h9;
        applyStimulus(s, 1'b0);
        checkOutput("mispred_ret", 11'b1011000_000_0, M_HAZ, 1'b0, 1'b0);

        s = idleStim(); s.M_icode = 4'h9;
        applyStimulus(s, 1'b0);
        checkOutput("ret_in_M", 11'b1010000_000_0, M_HAZ, 1'b0, 1'b0);

        s = idleStim(); s.E_icode = 4'h5; s.E_dstM = 4'h2; s.d_srcA = 4'h2;
        s.D_icode = 4'h9;
        applyStimulus(s, 1'b0);
        checkOutput("loaduse_ret", 11'b1101000_000_0, M_HAZ, 1'b0, 1'b0);

        s = idleStim(); s.E_icode = 4'h7; s.e_Cnd = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("jxx_taken", 11'b0000000_000_0, M_HAZ, 1'b0, 1'b0);

        s.e_Cnd = 1'b0;
        applyStimulus(s, 1'b0);
        checkOutput("mispred", 11'b0011000_000_0, M_HAZ, 1'b1, 1'b1);

        // Condition codes
        s = idleStim(); s.E_icode = 4'h6; s.alu_zf = 1'b0; s.alu_sf = 1'b1;
        s.alu_of = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("opq_set_cc", 11'b0000001_100_0, M_ALL, 1'b0, 1'b0);

        s = idleStim();
        applyStimulus(s, 1'b0);
        checkOutput("cc_loaded", 11'b0000000_011_0, M_ALL, 1'b0, 1'b0);

        s = idleStim(); s.E_icode = 4'h6; s.alu_zf = 1'b1; s.m_stat = 3'd3;
        applyStimulus(s, 1'b0);
        checkOutput("cc_gated_mstat", 11'b0000000_011_0, M_ALL, 1'b1, 1'b0);

        // Drain then halt
        s.W_stat = 3'd3;
        applyStimulus(s, 1'b0);
        checkOutput("drain", 11'b0000100_011_0, M_ALL, 1'b1, 1'b1);

        s = idleStim(); s.E_icode = 4'h7; s.e_Cnd = 1'b0; s.W_stat = 3'd3;
        applyStimulus(s, 1'b1);
        checkOutput("halted", 11'b1101110_011_1, M_ALL, 1'b1, 1'b1);

        s = idleStim(); s.E_icode = 4'h6; s.alu_zf = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("halted_opq_no_cc", 11'b1101110_011_1, M_ALL, 1'b1, 1'b1);

        applyStimulus(s, 1'b0);
        checkOutput("halted_frozen", 11'b1101110_011_1, M_ALL, 1'b1, 1'b1);

        // Reset out of HALTED, then reset again in the middle of DRAIN
        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("reset_from_halt", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);
        s = idleStim();
        for (int i = 0; i < 6; i++) applyStimulus(s, 1'b0);
        s.m_stat = 3'd3;
        checkOutput("pre_drain_cnt6", 11'b0000000_100_0, M_ALL, 1'b1, 1'b0);
        applyStimulus(s, 1'b0);
        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("reset_mid_drain", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);

        // Retirement counting
        s = idleStim(); s.W_icode = 4'h6;
        applyStimulus(s, 1'b0);
        checkOutput("cnt_start", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);
        s.W_icode = 4'h1;
        applyStimulus(s, 1'b0);
        checkOutput("retire_opq", 11'b0000000_100_0, M_HAZ, 1'b0, 1'b1);
        s.W_icode = 4'h3;
        applyStimulus(s, 1'b0);
        checkOutput("nop_not_counted", 11'b0000000_100_0, M_HAZ, 1'b0, 1'b1);
        s.W_icode = 4'h0; s.W_stat = 3'd2;
        applyStimulus(s, 1'b0);
        checkOutput("irmovq_counted", 11'b0000000_100_0, M_HAZ, 1'b0, 1'b1);
        s = idleStim(); s.W_icode = 4'h6;
        applyStimulus(s, 1'b1);
        checkOutput("halt_not_counted", 11'b1101110_100_1, M_ALL, 1'b1, 1'b1);
        applyStimulus(s, 1'b0);
        checkOutput("halted_no_retire", 11'b1101110_100_1, M_ALL, 1'b1, 1'b1);

        // Saturation of both counters
        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("reset_before_sat", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);
        s = idleStim(); s.W_icode = 4'h6;
        applyStimulus(s, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(s, 1'b0);
        checkOutput("saturate", 11'b0000000_100_0, M_ALL, 1'b1, 1'b1);

        // Let the monitor empty the queue, bounded
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain_queue: pending got %0d want 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage Y86-64 pipeline. It sits beside the execute stage.
- Detects load/use, ret and branch-mispredict hazards and drives stall/bubble to the F/D/E/M/W pipeline registers.
- Owns the architectural condition-code register (ZF/SF/OF) and generates set_cc.
- Runs a run/drain/halt state machine on exceptional status.
- Keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_cnt and instr_cnt (saturating)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
D_icode  in  4  icode in decode register
d_srcA  in  4  decode source A (4'hF = none)
d_srcB  in  4  decode source B (4'hF = none)
E_icode  in  4  icode in execute register
E_dstM  in  4  execute dstM (4'hF = none)
e_Cnd  in  1  execute condition result
alu_zf  in  1  ALU zero flag for current E operation
alu_sf  in  1  ALU sign flag
alu_of  in  1  ALU overflow flag
M_icode  in  4  icode in memory register
m_stat  in  3  memory-stage status (after dmem error)
W_icode  in  4  icode in writeback register
W_stat  in  3  writeback status
F_stall  out  1  hold fetch PC register
D_stall  out  1  hold decode register
D_bubble  out  1  load NOP into decode register
E_bubble  out  1  load NOP into execute register
M_bubble  out  1  load NOP into memory register
W_stall  out  1  hold writeback register
set_cc  out  1  CC update enable this cycle
ZF  out  1  CC zero flag (registered)
SF  out  1  CC sign flag (registered)
OF  out  1  CC overflow flag (registered)
halted  out  1  state == HALTED
cycle_cnt  out  CNT_W  cycles spent in RUN/DRAIN
instr_cnt  out  CNT_W  instructions retired

Behaviour:
- Encodings:
  - icode: HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
  - stat: AOK 1, HLT 2, ADR 3, INS 4.
  - A bubble is icode NOP.
- Reset (async, any time, including mid-drain):
  - state=RUN; ZF=1, SF=0, OF=0.
  - cycle_cnt=0, instr_cnt=0.
  - All stall/bubble outputs are combinational; with the input pipeline registers also reset they evaluate to 0.
- Hazard terms (combinational):
  - loaduse = E_icode∈{MRMOVQ,POPQ} && E_dstM!=F && E_dstM∈{d_srcA,d_srcB}.
  - ret = RET∈{D_icode,E_icode,M_icode}.
  - mispred = E_icode==JXX && !e_Cnd.
- RUN outputs:
  - F_stall = loaduse|ret.
  - D_stall = loaduse.
  - D_bubble = mispred | (ret & !loaduse).
  - E_bubble = mispred | loaduse.
  - M_bubble = 0; W_stall = 0.
  - set_cc = E_icode==OPQ.
- Simultaneous hazards:
  - loaduse+ret: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
  - mispred+ret-in-D: D_bubble=1, E_bubble=1, F_stall=1.
  - D_stall and D_bubble are never both 1.
- State machine:
  - RUN -> HALTED if W_stat!=AOK; else RUN -> DRAIN if m_stat!=AOK.
  - DRAIN -> HALTED when W_stat!=AOK.
  - HALTED is terminal until rst.
- DRAIN outputs:
  - Hazard outputs as in RUN.
  - M_bubble=1 (younger instructions must not write memory); set_cc=0.
- HALTED outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1.
- Exception gating of set_cc: set_cc is also forced to 0 in any state when m_stat!=AOK or W_stat!=AOK, same cycle.
- CC register: on clk, if set_cc then {ZF,SF,OF} <= {alu_zf,alu_sf,alu_of}; otherwise hold. The new flags are visible to an instruction entering E the next cycle.
- cycle_cnt: +1 each clk in RUN or DRAIN; holds in HALTED; saturates at all-ones.
- instr_cnt:
  - +1 when state!=HALTED && W_stat==AOK && W_icode!=NOP; saturates.
  - HALT retiring with W_stat=HLT is not counted.

Decomposition:
- Shared package y86_pkg: icode constants, stat constants, REG_NONE=4'hF, and the state enum {RUN, DRAIN, HALTED}.
- One sub-module, sat_counter (parameter W, inc, async rst), instantiated twice for cycle_cnt and instr_cnt.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-DRAIN with cycle_cnt=7.
  - Response: immediately state=RUN, ZF=1/SF=0/OF=0, counters 0, halted=0.
- Load/use:
  - Stimulus: E_icode=5, E_dstM=3, d_srcA=3.
  - Response: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
  - Stimulus: change to d_srcA=F, d_srcB=F.
  - Response: all 0.
- Mispredict:
  - Stimulus: E_icode=7, e_Cnd=0, D_icode=9.
  - Response: D_bubble=1, E_bubble=1, F_stall=1, D_stall=0.
- CC update:
  - Stimulus: E_icode=6, alu flags 0/1/1, statuses AOK.
  - Response: next cycle ZF=0, SF=1, OF=1.
  - Stimulus: same with m_stat=3.
  - Response: set_cc=0, flags unchanged.
- Drain/halt:
  - Stimulus: m_stat=3, then W_stat=3 on the next cycle.
  - Response: DRAIN with M_bubble=1 for one cycle, then HALTED; cycle_cnt frozen, all stalls asserted.
- Counting:
  - Stimulus: 4 cycles with W_icode=6,1,3,0 and W_stat=1,1,1,2.
  - Response: instr_cnt=2 after cycle 3; HALTED after cycle 4.
